pipeline_step_ctrl: RTL and testbench

Sequencer that owns the write enables of the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It lets the debug unit run the processor continuously, advance it one clock at a time, or freeze it. It also folds the hazard unit's stall and flush requests into per-latch controls. It sits between the debug unit, the hazard detection unit and the latch bank; latches sample its outputs on the falling clock edge.

---
 rtl/pipeline_step_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_step_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_step_ctrl.sv
// Pipeline step sequencer: run / single-step / halt control for the pipeline latch bank.
// Folds hazard stall and branch flush requests into per-latch write enables and flushes.
module pipeline_step_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             stop_req,
  input  logic             clear_req,
  input  logic             halt_wb,
  input  logic             hazard_stall,
  input  logic             branch_flush,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStep,
    StHalted
  } state_e;

  state_e           state_q, state_d;
  logic             run_prev_q, step_prev_q;
  logic             armed_q;
  logic             advance_q, advance_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_rise, step_rise;

  // armed_q masks the first edge after reset so a request already high is not seen as a rise.
  assign run_rise  = run_req & ~run_prev_q & armed_q;
  assign step_rise = step_req & ~step_prev_q & armed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_prev_q  <= 1'b0;
      step_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      advance_q   <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      run_prev_q  <= run_req;
      step_prev_q <= step_req;
      armed_q     <= 1'b1;
      advance_q   <= advance_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run_rise) begin
          state_d = StRun;
        end else if (step_rise) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (halt_wb && advance_q) begin
          state_d = StHalted;
        end else if (stop_req) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        state_d = halt_wb ? StHalted : StIdle;
      end
      StHalted: begin
        if (clear_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    advance_d = (state_d == StRun) || (state_d == StStep);
    running_d = (state_d == StRun);
    halted_d  = (state_d == StHalted);
  end

  // Counter wraps silently; clear only takes effect out of HALTED.
  always_comb begin
    cnt_d = cnt_q;
    if (advance_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((state_q == StHalted) && clear_req) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    pc_we       = advance_q & ~hazard_stall;
    if_id_we    = advance_q & ~hazard_stall;
    id_ex_we    = advance_q;
    ex_mem_we   = advance_q;
    mem_wb_we   = advance_q;
    id_ex_flush = advance_q & hazard_stall;
    if_id_flush = advance_q & branch_flush & ~hazard_stall;
    running     = running_q;
    halted      = halted_q;
    cycle_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Bench for pipeline_step_ctrl: per-cycle scoreboard against a behavioural model,
// a gating vector table, and hand-written step / run / halt / wrap / reset sequences.
module tb_pipeline_step_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run_req = 1'b0, step_req = 1'b0, stop_req = 1'b0, clear_req = 1'b0;
  logic halt_wb = 1'b0, hazard_stall = 1'b0, branch_flush = 1'b0;

  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush;
  logic running, halted;
  logic [31:0] cycle_cnt;

  logic pc_we4, if_id_we4, id_ex_we4, ex_mem_we4, mem_wb_we4, if_id_flush4, id_ex_flush4;
  logic running4, halted4;
  logic [3:0] cycle_cnt4;

  always #5 clk = ~clk;

  pipeline_step_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .clear_req(clear_req), .halt_wb(halt_wb), .hazard_stall(hazard_stall),
    .branch_flush(branch_flush), .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .running(running), .halted(halted), .cycle_cnt(cycle_cnt)
  );

  pipeline_step_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
    .clear_req(clear_req), .halt_wb(halt_wb), .hazard_stall(hazard_stall),
    .branch_flush(branch_flush), .pc_we(pc_we4), .if_id_we(if_id_we4), .id_ex_we(id_ex_we4),
    .ex_mem_we(ex_mem_we4), .mem_wb_we(mem_wb_we4), .if_id_flush(if_id_flush4),
    .id_ex_flush(id_ex_flush4), .running(running4), .halted(halted4), .cycle_cnt(cycle_cnt4)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Flag order: pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, running, halted
  function automatic logic [8:0] flags32();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
            running, halted};
  endfunction

  function automatic logic [8:0] flags4();
    return {pc_we4, if_id_we4, id_ex_we4, ex_mem_we4, mem_wb_we4, if_id_flush4, id_ex_flush4,
            running4, halted4};
  endfunction

  typedef struct {
    logic [8:0]  flags;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // Model state: 0 idle, 1 run, 2 step, 3 halted
  int          m_st = 0;
  bit          m_rp = 1'b0, m_sp = 1'b0, m_arm = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st  = 0;
      m_rp  = 1'b0;
      m_sp  = 1'b0;
      m_arm = 1'b0;
      m_cnt = 32'd0;
    end else begin
      bit   adv, rr, sr, a;
      exp_t e;
      adv   = (m_st == 1) || (m_st == 2);
      rr    = run_req && !m_rp && m_arm;
      sr    = step_req && !m_sp && m_arm;
      m_rp  = run_req;
      m_sp  = step_req;
      m_arm = 1'b1;
      if (adv) m_cnt = m_cnt + 32'd1;
      if (m_st == 0) begin
        if (rr) m_st = 1;
        else if (sr) m_st = 2;
      end else if (m_st == 1) begin
        if (halt_wb) m_st = 3;
        else if (stop_req) m_st = 0;
      end else if (m_st == 2) begin
        m_st = halt_wb ? 3 : 0;
      end else if (clear_req) begin
        m_st  = 0;
        m_cnt = 32'd0;
      end
      a = (m_st == 1) || (m_st == 2);
      e.flags = {a && !hazard_stall, a && !hazard_stall, a, a, a,
                 a && branch_flush && !hazard_stall, a && hazard_stall,
                 m_st == 1, m_st == 3};
      e.cnt = m_cnt;
      sb_q.push_back(e);
    end
  end

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("cycle_flags32", 32'(flags32()), 32'(e.flags));
        cmp("cycle_cnt32", cycle_cnt, e.cnt);
        cmp("cycle_flags4", 32'(flags4()), 32'(e.flags));
        cmp("cycle_cnt4", 32'(cycle_cnt4), {28'd0, e.cnt[3:0]});
      end
    end
  end

  typedef struct {
    bit         in_run;
    bit         stall;
    bit         flush;
    logic [6:0] exp;
  } gate_vec_t;

  gate_vec_t gv[8];

  initial begin
    int hi;
    bit in_run;

    // Gating: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    gv[0] = '{1'b0, 1'b0, 1'b0, 7'b0000000};
    gv[1] = '{1'b0, 1'b0, 1'b1, 7'b0000000};
    gv[2] = '{1'b0, 1'b1, 1'b0, 7'b0000000};
    gv[3] = '{1'b0, 1'b1, 1'b1, 7'b0000000};
    gv[4] = '{1'b1, 1'b0, 1'b0, 7'b1111100};
    gv[5] = '{1'b1, 1'b1, 1'b1, 7'b0011101};
    gv[6] = '{1'b1, 1'b0, 1'b1, 7'b1111110};
    gv[7] = '{1'b1, 1'b1, 1'b0, 7'b0011101};

    // Reset then idle
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    cmp("idle_flags", 32'(flags32()), 32'd0);
    cmp("idle_cnt", cycle_cnt, 32'd0);

    // Single step held for 5 cycles
    step_req = 1'b1;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pc_we && if_id_we && id_ex_we && ex_mem_we && mem_wb_we) hi++;
    end
    step_req = 1'b0;
    cmp("step_adv_cycles", 32'(hi), 32'd1);
    cmp("step_cnt", cycle_cnt, 32'd1);
    cmp("step_back_idle", 32'({running, halted}), 32'd0);

    // Run 20 cycles then stop
    run_req = 1'b1;
    repeat (20) @(negedge clk);
    cmp("run_running", 32'(running), 32'd1);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    run_req  = 1'b0;
    cmp("run_stop_cnt", cycle_cnt, 32'd21);
    cmp("run_stop_flags", 32'(flags32()), 32'd0);
    @(negedge clk);

    // Gating table: idle entries first, then run entries
    in_run = 1'b0;
    foreach (gv[i]) begin
      if (gv[i].in_run && !in_run) begin
        run_req = 1'b1;
        @(negedge clk);
        in_run = 1'b1;
      end
      hazard_stall = gv[i].stall;
      branch_flush = gv[i].flush;
      #1;
      cmp($sformatf("gate_vec%0d", i),
          32'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush}),
          32'(gv[i].exp));
      @(negedge clk);
    end
    hazard_stall = 1'b0;
    branch_flush = 1'b0;

    // Halt from run, step ignored, clear
    halt_wb = 1'b1;
    @(negedge clk);
    halt_wb = 1'b0;
    cmp("halt_flags", 32'(flags32()), 32'h001);
    step_req = 1'b1;
    repeat (3) @(negedge clk);
    step_req = 1'b0;
    @(negedge clk);
    cmp("halt_step_ignored", 32'(flags32()), 32'h001);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    cmp("clear_cnt", cycle_cnt, 32'd0);
    cmp("clear_idle", 32'(flags32()), 32'd0);
    run_req = 1'b0;
    @(negedge clk);

    // Wrap at CNT_W = 4 after 17 counted cycles
    run_req = 1'b1;
    repeat (18) @(negedge clk);
    cmp("wrap_cnt4", 32'(cycle_cnt4), 32'd1);
    cmp("wrap_cnt32", cycle_cnt, 32'd17);

    // Async reset between edges
    #2;
    reset = 1'b0;
    #1;
    cmp("async_rst_flags32", 32'(flags32()), 32'd0);
    cmp("async_rst_flags4", 32'(flags4()), 32'd0);
    cmp("async_rst_cnt", cycle_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    cmp("rst_release_no_run", 32'(flags32()), 32'd0);
    run_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
